// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: shared defines for the instruction prefetch queue
package instr_prefetch_queue_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DISCARD = 2'b10} pfq_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pfq_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// pfq_fifo: DEPTH-entry {pc,instr} ring buffer with flush
module pfq_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  pfq_entry_t       wdata,
    output pfq_entry_t       rdata,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    pfq_entry_t mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0] count_q, count_d;
    logic push_ok, pop_ok;
    always_comb begin
        push_ok = push && !flush;
        pop_ok = pop && !flush && count_q != '0;
        head_d = flush ? '0 : head_q + PTR_W'(pop_ok);
        tail_d = flush ? '0 : tail_q + PTR_W'(push_ok);
        count_d = flush ? '0 : count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(negedge CLK) begin
        if (push_ok) mem_q[tail_q] <= wdata;
    end
    assign rdata = mem_q[head_q];
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetch with redirect flush, one outstanding request
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] startPC,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    input  logic        fetchReady,
    output logic        fetchValid,
    output logic [31:0] fetchInstr,
    output logic [31:0] fetchPC,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    pfq_state_e state_q, state_d;
    logic mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d, next_fetch_q, next_fetch_d;
    logic push, pop, issue, empty;
    logic [PTR_W:0] count, cnt_after;
    pfq_entry_t head;
    pfq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .CLK(CLK), .Reset_L(Reset_L), .push(push), .pop(pop), .flush(redirect),
        .wdata('{pc: mem_addr_q, instr: memData}), .rdata(head), .empty(empty), .count(count)
    );
    always_comb begin
        state_d = state_q;
        mem_req_d = mem_req_q;
        mem_addr_d = mem_addr_q;
        next_fetch_d = next_fetch_q;
        push = 1'b0;
        issue = 1'b0;
        pop = fetchReady && !redirect && !empty;
        cnt_after = count + (PTR_W+1)'(1) - (PTR_W+1)'(pop);
        case (state_q)
            IDLE: issue = !redirect && count < DEPTH_C;
            WAIT: begin
                if (redirect) begin
                    state_d = memAck ? IDLE : DISCARD;
                    mem_req_d = !memAck;
                end else if (memAck) begin
                    push = 1'b1;
                    issue = cnt_after < DEPTH_C;
                    state_d = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            DISCARD: begin
                state_d = memAck ? IDLE : DISCARD;
                mem_req_d = !memAck;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = WAIT;
            mem_req_d = 1'b1;
            mem_addr_d = next_fetch_q;
            next_fetch_d = next_fetch_q + 32'd4;
        end
        if (redirect) next_fetch_d = redirectPC & 32'hFFFF_FFFC;
    end
    // nextFetch tracks startPC for as long as reset is held
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            mem_req_q <= 1'b0;
            mem_addr_q <= '0;
            next_fetch_q <= startPC;
        end else begin
            state_q <= state_d;
            mem_req_q <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            next_fetch_q <= next_fetch_d;
        end
    end
    assign fetchValid = !empty;
    assign fetchInstr = empty ? NOP_INSTR : head.instr;
    assign fetchPC = empty ? 32'h0 : head.pc;
    assign memReq = mem_req_q;
    assign memAddr = mem_addr_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: queue-based reference model, directed scenarios and random traffic
module tb_instr_prefetch_queue;
    logic CLK = 1'b0;
    logic Reset_L = 1'b1;
    logic [31:0] startPC = 32'h0;
    logic redirect = 1'b0;
    logic [31:0] redirectPC = 32'h0;
    logic fetchReady = 1'b0;
    logic fetchValid;
    logic [31:0] fetchInstr, fetchPC, memAddr;
    logic memReq;
    logic memAck = 1'b0;
    logic [31:0] memData = 32'h0;
    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];
    bit m_req, m_disc;
    logic [31:0] m_addr, m_nf;

    instr_prefetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC), .redirect(redirect),
        .redirectPC(redirectPC), .fetchReady(fetchReady), .fetchValid(fetchValid),
        .fetchInstr(fetchInstr), .fetchPC(fetchPC), .memReq(memReq), .memAddr(memAddr),
        .memAck(memAck), .memData(memData)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_req = 0;
        m_disc = 0;
        m_addr = 32'h0;
        m_nf = startPC;
    endtask

    // Applies the queue rules for one falling edge using the inputs currently driven
    task automatic model_edge();
        bit got, pre_req, pre_disc;
        int pre_n;
        if (!Reset_L) begin
            model_reset();
            return;
        end
        pre_req = m_req;
        pre_disc = m_disc;
        pre_n = q.size();
        got = pre_req && memAck;
        if (redirect) begin
            q.delete();
            m_nf = redirectPC & 32'hFFFF_FFFC;
            if (got) begin
                m_req = 0;
                m_disc = 0;
            end else if (pre_req) m_disc = 1;
        end else begin
            if (got && !pre_disc) q.push_back({m_addr, memData});
            if (fetchReady && pre_n > 0) void'(q.pop_front());
            if (got) begin
                m_req = 0;
                m_disc = 0;
            end
            if ((!pre_req && pre_n < 4) || (got && !pre_disc && q.size() < 4)) begin
                m_req = 1;
                m_addr = m_nf;
                m_nf = m_nf + 32'd4;
            end
        end
    endtask

    always @(posedge CLK) begin
        logic [63:0] h;
        h = (q.size() != 0) ? q[0] : 64'h0;
        chk("cmp_fetchValid", {31'h0, fetchValid}, {31'h0, q.size() != 0});
        chk("cmp_fetchPC", fetchPC, h[63:32]);
        chk("cmp_fetchInstr", fetchInstr, h[31:0]);
        chk("cmp_memReq", {31'h0, memReq}, {31'h0, m_req});
        chk("cmp_memAddr", memAddr, m_addr);
    end

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy,
                        input logic ak, input logic [31:0] dat);
        @(posedge CLK);
        redirect = rd;
        redirectPC = rpc;
        fetchReady = rdy;
        memAck = ak;
        memData = dat;
        @(negedge CLK);
        model_edge();
        #1;
    endtask

    task automatic mstep(input logic rd, input logic [31:0] rpc, input logic rdy);
        step(rd, rpc, rdy, m_req, mem_word(m_addr));
    endtask

    task automatic do_reset(input logic [31:0] pc);
        startPC = pc;
        Reset_L = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        Reset_L = 1'b1;
    endtask

    initial begin
        #1;
        do_reset(32'h0040_0000);
        chk("rst_fetchValid", {31'h0, fetchValid}, 32'h0);
        chk("rst_memReq", {31'h0, memReq}, 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        // sequential streaming with consumer always ready
        mstep(0, 0, 1);
        chk("t1_first_addr", memAddr, 32'h0040_0000);
        for (int k = 0; k < 6; k++) begin
            mstep(0, 0, 1);
            chk("t1_head_pc", fetchPC, 32'h0040_0000 + 32'(4 * k));
            chk("t1_head_instr", fetchInstr, mem_word(32'h0040_0000 + 32'(4 * k)));
            chk("t1_next_addr", memAddr, 32'h0040_0004 + 32'(4 * k));
        end
        // fill with consumer stalled, then drain
        do_reset(32'h0040_0000);
        for (int k = 0; k < 8; k++) mstep(0, 0, 0);
        chk("t2_full_memReq", {31'h0, memReq}, 32'h0);
        chk("t2_full_head", fetchPC, 32'h0040_0000);
        mstep(0, 0, 1);
        chk("t2_drain1", fetchPC, 32'h0040_0004);
        chk("t2_no_issue", {31'h0, memReq}, 32'h0);
        mstep(0, 0, 1);
        chk("t2_drain2", fetchPC, 32'h0040_0008);
        chk("t2_resume", memAddr, 32'h0040_0010);
        chk("t2_resume_req", {31'h0, memReq}, 32'h1);
        // redirect while a request is outstanding
        do_reset(32'h0040_0000);
        for (int k = 0; k < 3; k++) mstep(0, 0, 0);
        chk("t3_outstanding", memAddr, 32'h0040_0008);
        step(1, 32'h0040_0103, 0, 0, 0);
        chk("t3_req_held", {31'h0, memReq}, 32'h1);
        chk("t3_addr_held", memAddr, 32'h0040_0008);
        chk("t3_flushed", {31'h0, fetchValid}, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t3_dropped_valid", {31'h0, fetchValid}, 32'h0);
        chk("t3_dropped_instr", fetchInstr, 32'h0);
        mstep(0, 0, 0);
        chk("t3_new_addr", memAddr, 32'h0040_0100);
        chk("t3_wait_valid", {31'h0, fetchValid}, 32'h0);
        mstep(0, 0, 0);
        chk("t3_new_head", fetchPC, 32'h0040_0100);
        // redirect and pop on the same edge
        do_reset(32'h0040_0000);
        for (int k = 0; k < 3; k++) mstep(0, 0, 0);
        step(1, 32'h0040_0200, 1, 0, 0);
        chk("t4_valid", {31'h0, fetchValid}, 32'h0);
        chk("t4_instr", fetchInstr, 32'h0);
        chk("t4_pc", fetchPC, 32'h0);
        mstep(0, 0, 0);
        mstep(0, 0, 0);
        chk("t4_refetch", memAddr, 32'h0040_0200);
        // push and pop on the same edge, then address wrap
        do_reset(32'h0040_0000);
        mstep(0, 0, 0);
        mstep(0, 0, 0);
        mstep(0, 0, 1);
        chk("t5_head_pc", fetchPC, 32'h0040_0004);
        chk("t5_head_instr", fetchInstr, mem_word(32'h0040_0004));
        do_reset(32'hFFFF_FFFC);
        mstep(0, 0, 0);
        chk("t5_wrap_first", memAddr, 32'hFFFF_FFFC);
        mstep(0, 0, 0);
        chk("t5_wrap_next", memAddr, 32'h0000_0000);
        chk("t5_wrap_head", fetchPC, 32'hFFFF_FFFC);
        // asynchronous reset in the middle of a request
        do_reset(32'h0040_0000);
        mstep(0, 0, 0);
        startPC = 32'h0080_0040;
        @(posedge CLK);
        #2 Reset_L = 1'b0;
        model_reset();
        #1 chk("t6_async_memReq", {31'h0, memReq}, 32'h0);
        step(0, 0, 0, 1, 32'hBAD0_BAD0);
        step(0, 0, 0, 1, 32'hBAD0_BAD0);
        Reset_L = 1'b1;
        step(0, 0, 0, 1, 32'hBAD0_BAD0);
        chk("t6_first_addr", memAddr, 32'h0080_0040);
        chk("t6_ack_ignored", {31'h0, fetchValid}, 32'h0);
        // random traffic against the model
        do_reset(32'h0040_0000);
        for (int k = 0; k < 3000; k++) begin
            logic rd, rdy, ak;
            logic [31:0] rpc;
            rd = $urandom_range(0, 15) == 0;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rdy = $urandom_range(0, 1) == 1;
            ak = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            step(rd, rpc, rdy, ak, $urandom);
        end
        @(posedge CLK);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
